// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment scan driver: the hex font, the blank
// segment pattern and an index-width helper.
package seven_seg_pkg;

  // Active-high segment pattern that lights nothing.
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Hex font, {a,b,c,d,e,f,g} with bit 6 = a, active-high; entry 15 first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  // Width needed to index n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Single-digit hex to 7-segment decode, active-high segments.
module hex_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: shadowed display data, a slot
// prescaler with anti-ghosting dead time, per-digit masking, decimal points
// and leading-zero suppression, with configurable pin polarity.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD_CYCLES    = 1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic                                 load,
  input  logic [4*NUM_DIGITS-1:0]              value,
  input  logic [NUM_DIGITS-1:0]                dp_in,
  input  logic [NUM_DIGITS-1:0]                blank_mask,
  input  logic                                 lz_blank,
  output logic [6:0]                           seg,
  output logic                                 dp,
  output logic [NUM_DIGITS-1:0]                an,
  output logic [clog2_min1(NUM_DIGITS)-1:0]    digit_idx
);

  localparam int IW = clog2_min1(NUM_DIGITS);
  localparam int CW = clog2_min1(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD_CNT = CW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]             cnt;
  logic [IW-1:0]             idx;
  logic [4*NUM_DIGITS-1:0]   val_sh;
  logic [NUM_DIGITS-1:0]     dp_sh;
  logic [NUM_DIGITS-1:0]     mask_sh;

  logic [3:0]                cur_nib;
  logic [6:0]                dec_seg;
  logic                      upper_zero;
  logic                      visible;
  logic [NUM_DIGITS-1:0]     an_onehot;

  logic [6:0]                seg_p1;
  logic                      dp_p1;
  logic [NUM_DIGITS-1:0]     an_p1;
  logic [IW-1:0]             idx_p1;

  // Slot prescaler and digit counter; both freeze while the scan is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (en) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Shadow registers so the display never shows a half-updated word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_sh  <= '0;
      dp_sh   <= '0;
      mask_sh <= '0;
    end else if (load) begin
      val_sh  <= value;
      dp_sh   <= dp_in;
      mask_sh <= blank_mask;
    end
  end

  // Current digit's data: a digit above 0 is a leading zero when every
  // nibble from it upward is zero.
  assign cur_nib    = val_sh[{idx, 2'b00} +: 4];
  assign upper_zero = ((val_sh >> {idx, 2'b00}) == '0);
  assign visible    = ~mask_sh[idx] & ~(lz_blank & (idx != '0) & upper_zero);
  assign an_onehot  = NUM_DIGITS'(1) << idx;

  hex_seg_decode u_decode (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  // ---- stage p1: registered active-high outputs ----
  // Anodes stay dark during the dead cycles while segments already carry the
  // new slot's data; a disabled scan blanks everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p1 <= SEG_OFF;
      dp_p1  <= 1'b0;
      an_p1  <= '0;
      idx_p1 <= '0;
    end else begin
      idx_p1 <= idx;
      if (en) begin
        an_p1  <= (cnt < DEAD_CNT) ? '0 : an_onehot;
        seg_p1 <= visible ? dec_seg : SEG_OFF;
        dp_p1  <= dp_sh[idx];
      end else begin
        an_p1  <= '0;
        seg_p1 <= SEG_OFF;
        dp_p1  <= 1'b0;
      end
    end
  end

  // Pin polarity applied after the register, adding no latency.
  assign seg       = SEG_ACTIVE_LOW ? ~seg_p1 : seg_p1;
  assign dp        = SEG_ACTIVE_LOW ? ~dp_p1  : dp_p1;
  assign an        = AN_ACTIVE_LOW  ? ~an_p1  : an_p1;
  assign digit_idx = idx_p1;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: a 4-digit and a 1-digit instance, both
// with REFRESH_DIV=4, DEAD_CYCLES=1 and active-low pins, compared each cycle
// against a reference model derived from elapsed enabled cycles.
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        lz_blank;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  logic        load1;
  logic [3:0]  value1;
  logic [0:0]  dp_in1;
  logic [0:0]  blank_mask1;
  logic [6:0]  seg1;
  logic        dp1;
  logic [0:0]  an1;
  logic [0:0]  digit_idx1;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          ticks;
  logic [15:0] sh_val;
  logic [3:0]  sh_dp, sh_mask;
  logic [3:0]  sh_val1;
  logic        sh_dp1, sh_mask1;
  logic [13:0] exp4;
  logic [9:0]  exp1;
  logic [3:0]  exp_an;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
    .dp_in(dp_in), .blank_mask(blank_mask), .lz_blank(lz_blank),
    .seg(seg), .dp(dp), .an(an), .digit_idx(digit_idx)
  );

  seven_seg_scan_driver #(
    .NUM_DIGITS(1), .REFRESH_DIV(4), .DEAD_CYCLES(1),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load1), .value(value1),
    .dp_in(dp_in1), .blank_mask(blank_mask1), .lz_blank(lz_blank),
    .seg(seg1), .dp(dp1), .an(an1), .digit_idx(digit_idx1)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  function automatic bit shown(input logic [15:0] v, input logic [3:0] m,
                               input int i, input bit lz);
    return !m[i] && !(lz && i > 0 && (v >> (4 * i)) == 16'h0);
  endfunction

  task automatic model_reset();
    ticks = 0;
    sh_val = '0; sh_dp = '0; sh_mask = '0;
    sh_val1 = '0; sh_dp1 = 1'b0; sh_mask1 = 1'b0;
  endtask

  // Predict the pins after the coming edge from the pre-edge state, then
  // clock once and sample 1 time unit later.
  task automatic tick();
    int cnt, digit;
    logic [6:0] s, s1;
    logic d, d1, a1;
    cnt   = ticks % 4;
    digit = (ticks / 4) % 4;
    if (en) begin
      exp_an = (cnt < 1) ? 4'hF : ~(4'b0001 << digit);
      s  = shown(sh_val, sh_mask, digit, lz_blank) ? font(4'(sh_val >> (4 * digit))) : 7'h00;
      d  = sh_dp[digit];
      s1 = shown({12'h0, sh_val1}, {3'b0, sh_mask1}, 0, lz_blank) ? font(sh_val1) : 7'h00;
      d1 = sh_dp1;
      a1 = (cnt >= 1);
    end else begin
      exp_an = 4'hF;
      s = 7'h00; d = 1'b0; s1 = 7'h00; d1 = 1'b0; a1 = 1'b0;
    end
    exp4 = {~s, ~d, exp_an, 2'(digit)};
    exp1 = {~s1, ~d1, ~a1, 1'b0};
    @(posedge clk);
    if (en) ticks++;
    if (load) begin sh_val = value; sh_dp = dp_in; sh_mask = blank_mask; end
    if (load1) begin sh_val1 = value1; sh_dp1 = dp_in1[0]; sh_mask1 = blank_mask1[0]; end
    #1;
  endtask

  task automatic load_word(input logic [15:0] v, input logic [3:0] d, input logic [3:0] m);
    value = v; dp_in = d; blank_mask = m; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    load_word(16'h1234, 4'b0000, 4'b0000);
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({seg, dp, an, digit_idx} !== 14'b1111111_1_1111_00) begin
      errors++;
      $display("FAIL reset_async: got seg=%b dp=%b an=%b idx=%0d want seg=1111111 dp=1 an=1111 idx=0", seg, dp, an, digit_idx);
    end
    checks++;
    if ({seg1, dp1, an1} !== 9'b1111111_1_1) begin
      errors++;
      $display("FAIL reset_async_1dig: got seg=%b dp=%b an=%b want 1111111 1 1", seg1, dp1, an1);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({seg, dp, an, digit_idx} !== 14'b1111111_1_1111_00) begin
      errors++;
      $display("FAIL reset_held: got seg=%b dp=%b an=%b idx=%0d", seg, dp, an, digit_idx);
    end
    model_reset();
    rst_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++;
      if ({seg, dp, an, digit_idx} !== exp4) begin
        errors++;
        $display("FAIL reset_release c=%0d: got %b want %b", c, {seg, dp, an, digit_idx}, exp4);
      end
      if (c == 2) begin
        checks++;
        if (an !== 4'b1110) begin
          errors++;
          $display("FAIL reset_first_visible: got an=%b want 1110", an);
        end
      end
    end
  endtask

  task automatic test_scan_wrap();
    load_word(16'h1A2F, 4'b0000, 4'b0000);
    lz_blank = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if ({seg, dp, an, digit_idx} !== exp4) begin
        errors++;
        $display("FAIL scan_wrap c=%0d: got %b want %b", c, {seg, dp, an, digit_idx}, exp4);
      end
      if (exp_an != 4'hF) begin
        checks++;
        if (seg !== (exp_an == 4'b1110 ? 7'b0111000 : exp_an == 4'b1101 ? 7'b0010010 :
                     exp_an == 4'b1011 ? 7'b0001000 : 7'b1001111)) begin
          errors++;
          $display("FAIL scan_font an=%b: got seg=%b", an, seg);
        end
      end
    end
  endtask

  task automatic test_leading_zeros();
    logic [15:0] vals [3] = '{16'h0005, 16'h0000, 16'h0000};
    bit          lzs  [3] = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      lz_blank = lzs[k];
      load_word(vals[k], 4'b0000, 4'b0000);
      for (int c = 0; c < 20; c++) begin
        tick();
        checks++;
        if ({seg, dp, an, digit_idx} !== exp4) begin
          errors++;
          $display("FAIL leading_zero k=%0d c=%0d: got %b want %b", k, c, {seg, dp, an, digit_idx}, exp4);
        end
      end
    end
  endtask

  task automatic test_mask_dp();
    lz_blank = 1'b0;
    load_word(16'h8888, 4'b0001, 4'b0100);
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if ({seg, dp, an, digit_idx} !== exp4) begin
        errors++;
        $display("FAIL mask_dp c=%0d: got %b want %b", c, {seg, dp, an, digit_idx}, exp4);
      end
    end
  endtask

  task automatic test_enable_load();
    int guard;
    load_word(16'h4321, 4'b0000, 4'b0000);
    guard = 0;
    while (!((ticks % 4) == 2 && ((ticks / 4) % 4) == 1) && guard < 40) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 40) begin
      errors++;
      $display("FAIL enable_wait: digit 1 slot not reached, got ticks=%0d", ticks);
    end
    en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (an !== 4'hF || digit_idx !== 2'd1 || {seg, dp, an, digit_idx} !== exp4) begin
        errors++;
        $display("FAIL enable_hold c=%0d: got an=%b idx=%0d seg=%b want an=1111 idx=1", c, an, digit_idx, seg);
      end
    end
    en = 1'b1;
    guard = 0;
    while (!((ticks % 4) == 2 && ((ticks / 4) % 4) == 2) && guard < 40) begin
      tick();
      checks++;
      if ({seg, dp, an, digit_idx} !== exp4) begin
        errors++;
        $display("FAIL enable_resume: got %b want %b", {seg, dp, an, digit_idx}, exp4);
      end
      guard++;
    end
    load_word(16'hFFFF, 4'b0000, 4'b0000);
    tick();
    checks++;
    if (seg !== 7'b0111000 || an !== 4'b1011) begin
      errors++;
      $display("FAIL live_load: got seg=%b an=%b want seg=0111000 an=1011", seg, an);
    end
    for (int c = 0; c < 400; c++) begin
      en         = ($urandom_range(0, 7) != 0);
      lz_blank   = $urandom_range(0, 1);
      load       = ($urandom_range(0, 7) == 0);
      value      = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp_in      = 4'($urandom);
      blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      load1      = ($urandom_range(0, 7) == 0);
      value1     = 4'($urandom);
      dp_in1     = 1'($urandom);
      blank_mask1 = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if ({seg, dp, an, digit_idx} !== exp4) begin
        errors++;
        $display("FAIL random4 c=%0d: got %b want %b", c, {seg, dp, an, digit_idx}, exp4);
      end
      checks++;
      if ({seg1, dp1, an1, digit_idx1} !== exp1) begin
        errors++;
        $display("FAIL random1 c=%0d: got %b want %b", c, {seg1, dp1, an1, digit_idx1}, exp1);
      end
    end
    en = 1'b1; load = 1'b0; load1 = 1'b0; blank_mask1 = 1'b0; dp_in1 = 1'b0;
  endtask

  task automatic test_decode_sweep();
    en = 1'b1;
    for (int n = 0; n < 16; n++) begin
      value1 = 4'(n);
      load1  = 1'b1;
      tick();
      load1  = 1'b0;
      for (int c = 0; c < 5; c++) begin
        tick();
        checks++;
        if ({seg1, dp1, an1, digit_idx1} !== exp1) begin
          errors++;
          $display("FAIL decode n=%0d c=%0d: got %b want %b", n, c, {seg1, dp1, an1, digit_idx1}, exp1);
        end
      end
      checks++;
      if (seg1 !== ~font(4'(n))) begin
        errors++;
        $display("FAIL decode_font n=%0d: got seg=%b want %b", n, seg1, ~font(4'(n)));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; lz_blank = 1'b0; load = 1'b0;
    value = '0; dp_in = '0; blank_mask = '0;
    load1 = 1'b0; value1 = '0; dp_in1 = '0; blank_mask1 = '0;
    model_reset();
    #12;
    rst_n = 1'b1;
    en = 1'b1;
    test_reset();
    test_scan_wrap();
    test_leading_zeros();
    test_mask_dp();
    test_enable_load();
    test_decode_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
